// File: rtl/pll_reconfig_pkg.sv
// Shared encodings, FSM states and shadow-bank geometry for the PLL reconfiguration responder.
package pll_reconfig_pkg;

  localparam int CHAIN_LEN = 90;
  localparam int NUM_CNT   = 5;
  localparam int CNT_BITS  = 18;

  localparam logic [3:0] CT_N  = 4'b0000;
  localparam logic [3:0] CT_M  = 4'b0001;
  localparam logic [3:0] CT_C0 = 4'b0100;
  localparam logic [3:0] CT_C1 = 4'b0101;
  localparam logic [3:0] CT_C2 = 4'b0110;

  localparam logic [2:0] CP_HIGH   = 3'b000;
  localparam logic [2:0] CP_LOW    = 3'b001;
  localparam logic [2:0] CP_BYPASS = 3'b100;
  localparam logic [2:0] CP_ODD    = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_SHIFT, S_UPDATE, S_DONE} state_t;
  typedef enum logic [1:0] {F_HIGH, F_LOW, F_BYP, F_ODD} field_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] idx;
    field_t     fld;
  } addr_t;

  // Bank index 0 is N and 4 is C2, so C2 lands in the MSBs of the scan chain.
  function automatic addr_t decode_addr(input logic [3:0] ctype, input logic [2:0] cparam);
    addr_t a;
    a.ok  = 1'b1;
    a.idx = 3'd0;
    a.fld = F_HIGH;
    case (ctype)
      CT_N:    a.idx = 3'd0;
      CT_M:    a.idx = 3'd1;
      CT_C0:   a.idx = 3'd2;
      CT_C1:   a.idx = 3'd3;
      CT_C2:   a.idx = 3'd4;
      default: a.ok  = 1'b0;
    endcase
    case (cparam)
      CP_HIGH:   a.fld = F_HIGH;
      CP_LOW:    a.fld = F_LOW;
      CP_BYPASS: a.fld = F_BYP;
      CP_ODD:    a.fld = F_ODD;
      default:   a.ok  = 1'b0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/pll_scan_shifter.sv
// Serializes the scan chain MSB first at half the system clock; data moves only on the low phase.
module pll_scan_shifter
  import pll_reconfig_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CHAIN_LEN-1:0] vec_i,
  output logic                 last_o,
  output logic                 scanclk_o,
  output logic                 scandata_o
);

  logic [CHAIN_LEN-1:0] sr_q;
  logic [6:0]           cnt_q;
  logic                 active_q;

  assign last_o = active_q & scanclk_o & (cnt_q == 7'(CHAIN_LEN - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      active_q   <= 1'b0;
      scanclk_o  <= 1'b0;
      scandata_o <= 1'b0;
    end else if (start_i) begin
      active_q   <= 1'b1;
      scanclk_o  <= 1'b0;
      scandata_o <= vec_i[CHAIN_LEN-1];
      sr_q       <= {vec_i[CHAIN_LEN-2:0], 1'b0};
      cnt_q      <= '0;
    end else if (active_q) begin
      if (!scanclk_o) begin
        scanclk_o <= 1'b1;
      end else if (last_o) begin
        active_q   <= 1'b0;
        scanclk_o  <= 1'b0;
        scandata_o <= 1'b0;
      end else begin
        // Next bit is presented on the same edge that drops scanclk.
        scanclk_o  <= 1'b0;
        scandata_o <= sr_q[CHAIN_LEN-1];
        sr_q       <= {sr_q[CHAIN_LEN-2:0], 1'b0};
        cnt_q      <= cnt_q + 7'd1;
      end
    end
  end

endmodule

// File: rtl/pll_reconfig_responder.sv
// Command responder holding the PLL counter shadow bank and driving the scan-chain reconfiguration.
module pll_reconfig_responder
  import pll_reconfig_pkg::*;
(
  input  logic       clock_ctr,
  input  logic       sys_reset,
  input  logic       reset_ctr,
  input  logic [3:0] counter_type_ctr,
  input  logic [2:0] counter_param_ctr,
  input  logic [8:0] config_data_in,
  input  logic       write_param_ctr,
  input  logic       pll_read_param,
  input  logic       reconfig_ctr,
  input  logic       pll_areset_in_ctr,
  output logic       busy_ctr,
  output logic [8:0] config_data_out,
  output logic       pll_scanclk,
  output logic       pll_scandata,
  output logic       pll_configupdate,
  output logic       pll_areset
);

  logic rst;
  assign rst = sys_reset | reset_ctr;

  state_t state_q, state_d;
  logic   wr_q, rd_q, rc_q;
  logic   wr_edge, rd_edge, rc_edge;
  logic   start, shift_last;
  addr_t  addr_q;
  logic [7:0] din_q;
  logic [8:0] rd_data;
  logic [CHAIN_LEN-1:0] chain;

  logic [NUM_CNT-1:0][7:0] high_q, low_q;
  logic [NUM_CNT-1:0]      byp_q, odd_q;

  // Counts use only the low byte; the top data bit has no destination.
  logic unused_din;
  assign unused_din = config_data_in[8];

  // Registers track the level every cycle, so a level held across a busy window never re-triggers.
  assign wr_edge = write_param_ctr & ~wr_q;
  assign rd_edge = pll_read_param  & ~rd_q;
  assign rc_edge = reconfig_ctr    & ~rc_q;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rc_edge) begin
          state_d = S_SHIFT;
          start   = 1'b1;
        end else if (wr_edge) begin
          state_d = S_WRITE;
        end else if (rd_edge) begin
          state_d = S_READ;
        end
      end
      S_WRITE, S_READ: state_d = S_DONE;
      S_SHIFT:         if (shift_last) state_d = S_UPDATE;
      S_UPDATE:        state_d = S_DONE;
      default:         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_ctr) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    chain = '0;
    for (int i = 0; i < NUM_CNT; i++)
      chain[i*CNT_BITS +: CNT_BITS] = {high_q[i], byp_q[i], low_q[i], odd_q[i]};
  end

  always_comb begin
    rd_data = '0;
    if (addr_q.ok) begin
      case (addr_q.fld)
        F_HIGH: rd_data = {1'b0, high_q[addr_q.idx]};
        F_LOW:  rd_data = {1'b0, low_q[addr_q.idx]};
        F_BYP:  rd_data = {8'd0, byp_q[addr_q.idx]};
        F_ODD:  rd_data = {8'd0, odd_q[addr_q.idx]};
      endcase
    end
  end

  always_ff @(posedge clock_ctr) begin
    if (rst) begin
      wr_q             <= 1'b0;
      rd_q             <= 1'b0;
      rc_q             <= 1'b0;
      busy_ctr         <= 1'b0;
      pll_configupdate <= 1'b0;
      config_data_out  <= '0;
      addr_q           <= '0;
      din_q            <= '0;
      high_q           <= {NUM_CNT{8'd1}};
      low_q            <= {NUM_CNT{8'd1}};
      byp_q            <= '0;
      odd_q            <= '0;
    end else begin
      wr_q             <= write_param_ctr;
      rd_q             <= pll_read_param;
      rc_q             <= reconfig_ctr;
      busy_ctr         <= (state_d != S_IDLE);
      pll_configupdate <= (state_d == S_UPDATE);
      if (state_q == S_IDLE) begin
        addr_q <= decode_addr(counter_type_ctr, counter_param_ctr);
        din_q  <= config_data_in[7:0];
      end
      if (state_q == S_WRITE && addr_q.ok) begin
        case (addr_q.fld)
          F_HIGH: high_q[addr_q.idx] <= din_q;
          F_LOW:  low_q[addr_q.idx]  <= din_q;
          F_BYP:  byp_q[addr_q.idx]  <= din_q[0];
          F_ODD:  odd_q[addr_q.idx]  <= din_q[0];
        endcase
      end
      if (state_q == S_READ) config_data_out <= rd_data;
    end
  end

  always_ff @(posedge clock_ctr) pll_areset <= pll_areset_in_ctr | sys_reset;

  pll_scan_shifter u_shifter (
    .clk_i      (clock_ctr),
    .rst_i      (rst),
    .start_i    (start),
    .vec_i      (chain),
    .last_o     (shift_last),
    .scanclk_o  (pll_scanclk),
    .scandata_o (pll_scandata)
  );

endmodule
